// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: pixel-domain pattern stage behind display_480p.
// Tracks the active-pixel position from rgb_en and v_sync. It then produces one of
// four test patterns on 4-bit RGB. The syncs are re-registered so that colour and
// sync reach the VGA pins on the same edge.
// Optional feature: define MOVING_BOX_EN to overlay a bouncing 32x32 white box.
module vga_pattern_gen #(
    parameter int   CORDW       = 10,
    parameter int   H_ACTIVE    = 640,
    parameter int   V_ACTIVE    = 480,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   CHECK_LOG2  = 5
) (
    input  logic       clk_pix,
    input  logic       rst,
    input  logic       h_sync,
    input  logic       v_sync,
    input  logic       rgb_en,
    input  logic [1:0] mode,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b
);

    // Bars need an integer bar width, the box needs room to bounce, and the
    // checker bit must exist in the coordinate.
    if ((H_ACTIVE % 8) != 0 || V_ACTIVE < 32 || H_ACTIVE < 32 || CHECK_LOG2 >= CORDW) begin : g_bad_cfg
        $error("vga_pattern_gen: unsupported parameter combination");
    end

    localparam logic [CORDW-1:0] BAR_LAST = CORDW'(H_ACTIVE / 8 - 1);

    logic [CORDW-1:0] x;
    logic [CORDW-1:0] y;
    logic [CORDW-1:0] bar_px;
    logic [2:0]       bar_idx;
    logic [1:0]       mode_q;
    logic             synced;
    logic             v_sync_q;
    logic             rgb_en_q;
    logic             frame_start;
    logic             line_end;
    logic [11:0]      colour;

    // y stops at its maximum rather than wrapping when v_sync goes missing
    function automatic logic [CORDW-1:0] sat_inc(input logic [CORDW-1:0] v);
        return (v == {CORDW{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Fixed eight-bar order; each component is either full or off
    function automatic logic [11:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 12'hFFF;  // white
            3'd1:    return 12'hFF0;  // yellow
            3'd2:    return 12'h0FF;  // cyan
            3'd3:    return 12'h0F0;  // green
            3'd4:    return 12'hF0F;  // magenta
            3'd5:    return 12'hF00;  // red
            3'd6:    return 12'h00F;  // blue
            default: return 12'h000;  // black
        endcase
    endfunction

    assign frame_start = (v_sync == SYNC_ACTIVE) && (v_sync_q != SYNC_ACTIVE);
    assign line_end    = rgb_en_q && !rgb_en;

    // Position tracking. A frame start overrides a coincident line end, so y restarts at 0.
    always_ff @(posedge clk_pix or negedge rst) begin
        if (!rst) begin
            x        <= '0;
            y        <= '0;
            bar_px   <= '0;
            bar_idx  <= '0;
            mode_q   <= '0;
            synced   <= 1'b0;
            v_sync_q <= ~SYNC_ACTIVE;
            rgb_en_q <= 1'b0;
        end else begin
            v_sync_q <= v_sync;
            rgb_en_q <= rgb_en;
            if (frame_start) begin
                x       <= '0;
                y       <= '0;
                bar_px  <= '0;
                bar_idx <= '0;
                mode_q  <= mode;
                synced  <= 1'b1;
            end else if (line_end) begin
                x       <= '0;
                y       <= sat_inc(y);
                bar_px  <= '0;
                bar_idx <= '0;
            end else if (rgb_en) begin
                x <= x + 1'b1;
                if (bar_px == BAR_LAST) begin
                    bar_px  <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_px <= bar_px + 1'b1;
                end
            end
        end
    end

`ifdef MOVING_BOX_EN
    localparam logic [CORDW-1:0] BX_MAX = CORDW'(H_ACTIVE - 32);
    localparam logic [CORDW-1:0] BY_MAX = CORDW'(V_ACTIVE - 32);

    logic [CORDW-1:0] bx;
    logic [CORDW-1:0] by;
    logic             bx_up;
    logic             by_up;
    logic             in_box;

    // The box steps once per frame start after the first, so frame 0 shows it at (0,0)
    always_ff @(posedge clk_pix or negedge rst) begin
        if (!rst) begin
            bx    <= '0;
            by    <= '0;
            bx_up <= 1'b1;
            by_up <= 1'b1;
        end else if (frame_start && synced) begin
            if (bx_up) begin
                if (bx == BX_MAX) begin
                    bx_up <= 1'b0;
                    bx    <= bx - 1'b1;
                end else begin
                    bx <= bx + 1'b1;
                end
            end else begin
                if (bx == '0) begin
                    bx_up <= 1'b1;
                    bx    <= bx + 1'b1;
                end else begin
                    bx <= bx - 1'b1;
                end
            end
            if (by_up) begin
                if (by == BY_MAX) begin
                    by_up <= 1'b0;
                    by    <= by - 1'b1;
                end else begin
                    by <= by + 1'b1;
                end
            end else begin
                if (by == '0) begin
                    by_up <= 1'b1;
                    by    <= by + 1'b1;
                end else begin
                    by <= by - 1'b1;
                end
            end
        end
    end

    // One extra bit so the box's far edge cannot wrap.
    assign in_box = ({1'b0, x} >= {1'b0, bx}) && ({1'b0, x} < ({1'b0, bx} + (CORDW+1)'(32))) &&
                    ({1'b0, y} >= {1'b0, by}) && ({1'b0, y} < ({1'b0, by} + (CORDW+1)'(32)));
`endif

    // Pattern colour for the current position
    always_comb begin
        colour = 12'h000;
        case (mode_q)
            2'd0:    colour = 12'hF00;
            2'd1:    colour = bar_colour(bar_idx);
            2'd2:    colour = (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? 12'hFFF : 12'h000;
            default: colour = {x[CORDW-1 -: 4], y[CORDW-2 -: 4], 4'h8};
        endcase
`ifdef MOVING_BOX_EN
        if (in_box) colour = 12'hFFF;
`endif
    end

    // Output register: colour and syncs leave together; black when blanked or before the first frame
    always_ff @(posedge clk_pix or negedge rst) begin
        if (!rst) begin
            vga_hs <= ~SYNC_ACTIVE;
            vga_vs <= ~SYNC_ACTIVE;
            vga_r  <= 4'h0;
            vga_g  <= 4'h0;
            vga_b  <= 4'h0;
        end else begin
            vga_hs <= h_sync;
            vga_vs <= v_sync;
            {vga_r, vga_g, vga_b} <= (synced && rgb_en) ? colour : 12'h000;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Testbench for vga_pattern_gen with the default 640x480 parameters and negative syncs.
// Lines are driven directly. Short lines, with one active pixel each, reach deep rows cheaply.
module tb_vga_pattern_gen;

    logic       clk_pix = 1'b0;
    logic       rst;
    logic       h_sync;
    logic       v_sync;
    logic       rgb_en;
    logic [1:0] mode;
    logic       vga_hs;
    logic       vga_vs;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;

    int total  = 0;
    int passed = 0;

    always #20 clk_pix = ~clk_pix;

    vga_pattern_gen dut (
        .clk_pix(clk_pix),
        .rst    (rst),
        .h_sync (h_sync),
        .v_sync (v_sync),
        .rgb_en (rgb_en),
        .mode   (mode),
        .vga_hs (vga_hs),
        .vga_vs (vga_vs),
        .vga_r  (vga_r),
        .vga_g  (vga_g),
        .vga_b  (vga_b)
    );

    typedef struct packed {
        logic [1:0]  mode;
        logic [9:0]  py;
        logic [9:0]  px;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[20];

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [11:0] rgb();
        return {vga_r, vga_g, vga_b};
    endfunction

    // v_sync high -> low (frame start, mode latched) -> high again
    task automatic start_frame(input logic [1:0] m);
        mode   = m;
        rgb_en = 1'b0;
        v_sync = 1'b1;
        tick();
        v_sync = 1'b0;
        tick();
        tick();
        v_sync = 1'b1;
        tick();
    endtask

    task automatic short_lines(input int n);
        repeat (n) begin
            rgb_en = 1'b1;
            tick();
            rgb_en = 1'b0;
            tick();
        end
    endtask

    // After this, the output shows the colour of pixel px on the current line.
    task automatic run_to_pixel(input int px);
        rgb_en = 1'b1;
        repeat (px + 1) tick();
    endtask

    task automatic end_line();
        rgb_en = 1'b0;
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
        $fatal(1, "timeout");
    end

    initial begin
        //                mode   row     col     colour
        vecs[0]  = '{2'd1, 10'd0,   10'd0,   12'hFFF};
        vecs[1]  = '{2'd1, 10'd0,   10'd79,  12'hFFF};
        vecs[2]  = '{2'd1, 10'd0,   10'd80,  12'hFF0};
        vecs[3]  = '{2'd1, 10'd0,   10'd160, 12'h0FF};
        vecs[4]  = '{2'd1, 10'd0,   10'd240, 12'h0F0};
        vecs[5]  = '{2'd1, 10'd0,   10'd320, 12'hF0F};
        vecs[6]  = '{2'd1, 10'd0,   10'd400, 12'hF00};
        vecs[7]  = '{2'd1, 10'd0,   10'd480, 12'h00F};
        vecs[8]  = '{2'd1, 10'd0,   10'd560, 12'h000};
        vecs[9]  = '{2'd1, 10'd0,   10'd639, 12'h000};
        vecs[10] = '{2'd1, 10'd5,   10'd85,  12'hFF0};
        vecs[11] = '{2'd2, 10'd0,   10'd0,   12'h000};
        vecs[12] = '{2'd2, 10'd0,   10'd31,  12'h000};
        vecs[13] = '{2'd2, 10'd0,   10'd32,  12'hFFF};
        vecs[14] = '{2'd2, 10'd32,  10'd32,  12'h000};
        vecs[15] = '{2'd2, 10'd479, 10'd639, 12'hFFF};
        vecs[16] = '{2'd3, 10'd0,   10'd0,   12'h008};
        vecs[17] = '{2'd3, 10'd200, 10'd100, 12'h168};
        vecs[18] = '{2'd0, 10'd5,   10'd5,   12'hF00};
        vecs[19] = '{2'd3, 10'd0,   10'd639, 12'h908};

        // Reset state, with inputs set to the opposite of the reset values
        rst    = 1'b0;
        h_sync = 1'b0;
        v_sync = 1'b0;
        rgb_en = 1'b1;
        mode   = 2'd1;
        tick();
        tick();
        check("reset_rgb", rgb(), 12'h000);
        check("reset_syncs", {10'd0, vga_hs, vga_vs}, 12'h003);
        h_sync = 1'b1;
        v_sync = 1'b1;
        rgb_en = 1'b0;
        tick();
        rst = 1'b1;

        // Before the first frame start, the output stays black even while rgb_en is high
        run_to_pixel(3);
        check("pre_sync_black", rgb(), 12'h000);
        end_line();

        // Table of pattern pixels, each starting from a fresh frame
        for (int i = 0; i < 20; i++) begin
            start_frame(vecs[i].mode);
            short_lines(int'(vecs[i].py));
            run_to_pixel(int'(vecs[i].px));
            check($sformatf("vec%0d_m%0d_x%0d_y%0d", i, vecs[i].mode, vecs[i].px, vecs[i].py),
                  rgb(), vecs[i].exp);
            end_line();
            if (i == 18) check("blank_after_en_low", rgb(), 12'h000);
        end

        // Asynchronous reset in the middle of a line
        start_frame(2'd0);
        run_to_pixel(10);
        check("pre_reset_red", rgb(), 12'hF00);
        h_sync = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async_reset_rgb", rgb(), 12'h000);
        check("async_reset_syncs", {10'd0, vga_hs, vga_vs}, 12'h003);
        tick();
        h_sync = 1'b1;
        rst    = 1'b1;
        run_to_pixel(5);
        check("post_reset_black", rgb(), 12'h000);
        end_line();
        start_frame(2'd0);
        run_to_pixel(5);
        check("post_reset_resync", rgb(), 12'hF00);
        end_line();

        // A mode change in the middle of a frame waits for the next frame start
        start_frame(2'd0);
        short_lines(200);
        mode = 2'd3;
        run_to_pixel(5);
        check("mid_frame_mode_ignored", rgb(), 12'hF00);
        end_line();
        short_lines(5);
        start_frame(2'd3);
        run_to_pixel(639);
        check("next_frame_gradient", rgb(), 12'h908);
        end_line();

        // Sync passthrough: no change before the edge, the new value after it
        begin
            logic [1:0] prev;
            logic [4:0] cnt;
            prev   = {vga_hs, vga_vs};
            rgb_en = 1'b0;
            for (int i = 0; i < 16; i++) begin
                cnt    = 5'(i);
                h_sync = cnt[0];
                v_sync = cnt[1] ^ cnt[3];
                check($sformatf("sync_hold_%0d", i), {10'd0, vga_hs, vga_vs}, {10'd0, prev});
                tick();
                check($sformatf("sync_pass_%0d", i), {10'd0, vga_hs, vga_vs}, {10'd0, h_sync, v_sync});
                prev = {h_sync, v_sync};
            end
            h_sync = 1'b1;
            v_sync = 1'b1;
            tick();
        end

        // Frame start and end of line on the same cycle: y must restart at 0, not 32
        start_frame(2'd2);
        short_lines(31);
        rgb_en = 1'b1;
        tick();
        rgb_en = 1'b0;
        v_sync = 1'b0;
        tick();
        tick();
        v_sync = 1'b1;
        tick();
        run_to_pixel(0);
        check("frame_start_beats_line_end", rgb(), 12'h000);
        end_line();

        // Without v_sync, y saturates at 1023 and does not wrap to 6
        start_frame(2'd3);
        short_lines(1030);
        run_to_pixel(0);
        check("y_saturates", rgb(), 12'h0F8);
        end_line();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
